// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - funct3 codes and FSM state encoding for the MEM stage
package mem_access_stage_pkg;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// rtl/mem_access_stage_load_store_align.sv - byte-lane steering, load extend and alignment check
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] load_value,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};

    // funct3[1:0] is the access size for loads and stores alike
    case ({1'b0, funct3[1:0]})
      F3_SB: begin
        wdata      = {8{store_data[7:0]}};
        wmask      = 8'h01 << offset;
        misaligned = 1'b0;
      end
      F3_SH: begin
        wdata      = {4{store_data[15:0]}};
        wmask      = 8'h03 << offset;
        misaligned = offset[0];
      end
      F3_SW: begin
        wdata      = {2{store_data[31:0]}};
        wmask      = 8'h0F << offset;
        misaligned = |offset[1:0];
      end
      default: begin
        wdata      = store_data;
        wmask      = 8'hFF;
        misaligned = |offset;
      end
    endcase

    case (funct3)
      F3_LB:   load_value = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_value = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_value = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   load_value = shifted;
      F3_LBU:  load_value = {56'd0, shifted[7:0]};
      F3_LHU:  load_value = {48'd0, shifted[15:0]};
      F3_LWU:  load_value = {32'd0, shifted[31:0]};
      default: load_value = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV64I memory-access stage with valid/ready data-memory handshake
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [XLEN-1:0]   store_data,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memToReg,
  input  logic              regWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic              misaligned,
  output logic [ADDR_W-1:0] address_out,
  output logic [XLEN-1:0]   value_out,
  output logic [4:0]        rd_out,
  output logic              memToReg_out,
  output logic              regWrite_out
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   load_q, load_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [XLEN-1:0]   lat_data_q, lat_data_d;
  logic [2:0]        lat_f3_q, lat_f3_d;
  logic [4:0]        lat_rd_q, lat_rd_d;
  logic              lat_we_q, lat_we_d;
  logic              lat_m2r_q, lat_m2r_d;
  logic              lat_rw_q, lat_rw_d;

  logic              idle, is_memop;
  logic [ADDR_W-1:0] cur_addr;
  logic [XLEN-1:0]   cur_data;
  logic [2:0]        cur_f3;
  logic [XLEN-1:0]   al_wdata, al_load;
  logic [7:0]        al_wmask;
  logic              al_mis;

  // One aligner serves both the live instruction (IDLE) and the latched one
  assign idle     = (state_q == ST_IDLE);
  assign is_memop = memRead | memWrite;
  assign cur_addr = idle ? address    : lat_addr_q;
  assign cur_data = idle ? store_data : lat_data_q;
  assign cur_f3   = idle ? funct3     : lat_f3_q;

  load_store_align u_align (
    .funct3     (cur_f3),
    .offset     (cur_addr[2:0]),
    .store_data (cur_data),
    .rdata      (load_q),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .load_value (al_load),
    .misaligned (al_mis)
  );

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    lat_addr_d   = lat_addr_q;
    lat_data_d   = lat_data_q;
    lat_f3_d     = lat_f3_q;
    lat_rd_d     = lat_rd_q;
    lat_we_d     = lat_we_q;
    lat_m2r_d    = lat_m2r_q;
    lat_rw_d     = lat_rw_q;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = {cur_addr[ADDR_W-1:3], 3'b000};
    dmem_wdata   = '0;
    dmem_wmask   = '0;
    stall        = 1'b0;
    misaligned   = 1'b0;
    address_out  = cur_addr;
    value_out    = '0;
    rd_out       = idle ? rd : lat_rd_q;
    memToReg_out = idle ? memToReg : lat_m2r_q;
    regWrite_out = 1'b0;

    case (state_q)
      ST_IDLE: begin
        regWrite_out = regWrite;
        if (is_memop) begin
          regWrite_out = 1'b0;
          if (al_mis) begin
            misaligned = 1'b1;
          end else begin
            lat_addr_d = address;
            lat_data_d = store_data;
            lat_f3_d   = funct3;
            lat_rd_d   = rd;
            lat_we_d   = memWrite;
            lat_m2r_d  = memToReg;
            lat_rw_d   = regWrite;
            stall      = 1'b1;
            state_d    = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        dmem_req   = 1'b1;
        dmem_we    = lat_we_q;
        dmem_wdata = al_wdata;
        dmem_wmask = al_wmask;
        stall      = 1'b1;
        if (dmem_ready) begin
          load_d  = dmem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        value_out    = lat_we_q ? '0 : al_load;
        regWrite_out = lat_rw_q & ~lat_we_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      load_q     <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      lat_f3_q   <= '0;
      lat_rd_q   <= '0;
      lat_we_q   <= 1'b0;
      lat_m2r_q  <= 1'b0;
      lat_rw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_f3_q   <= lat_f3_d;
      lat_rd_q   <= lat_rd_d;
      lat_we_q   <= lat_we_d;
      lat_m2r_q  <= lat_m2r_d;
      lat_rw_q   <= lat_rw_d;
    end
  end

endmodule
